keypad_scanner: RTL

- Drives the 4x4 matrix keypad columns, samples the rows, debounces the result, and emits one clean key event per physical press.
- Its key codes are the input alphabet of the vending-machine FSM: digits, OK = 4'hF, confirm = 4'hE, dispense = 4'hD.
- Sits between the board keypad pins and the vending-machine control logic. It replaces per-bit debouncing with scan-level validation.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_decode.sv | 29 ++
 rtl/keypad_scanner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, scan result
// record and the row/column to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  localparam logic [3:0] KEY_OK       = 4'hF;
  localparam logic [3:0] KEY_CONFIRM  = 4'hE;
  localparam logic [3:0] KEY_DISPENSE = 4'hD;
  localparam logic [3:0] KEY_STAR     = 4'hE;

  typedef struct packed {
    logic       single;
    logic       none;
    logic       multi;
    logic [3:0] code;
  } scan_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = KEY_STAR;
      4'hD: k = 4'h0;
      4'hE: k = KEY_OK;
      4'hF: k = KEY_DISPENSE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Classifies a full-scan snapshot (bit 4*col+row, active-low) as no key,
// exactly one key (with its code) or several keys.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [15:0] snapshot,
  output scan_t       result
);

  logic [4:0] n_low;
  logic [3:0] code;

  always_comb begin
    n_low = '0;
    code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snapshot[i]) begin
        n_low = n_low + 5'd1;
        code  = key_map(i[1:0], i[3:2]);
      end
    end
  end

  assign result.single = (n_low == 5'd1);
  assign result.none   = (n_low == 5'd0);
  assign result.multi  = (n_low >  5'd1);
  assign result.code   = code;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold column drive, per-slot row capture, and a
// scan-level debounce FSM that emits one key event per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]        row_s1, row_s2;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic [15:0]       snapshot;
  logic              scan_done;
  logic              slot_last;
  scan_t             res;

  assign slot_last = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      slot_cnt  <= '0;
      col_idx   <= '0;
      shift_col <= 4'b1110;
      snapshot  <= '1;
      scan_done <= 1'b0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      // FSM consumes the snapshot the cycle after the col-3 capture completes it
      scan_done <= slot_last && (col_idx == 2'd3);
      if (slot_last) begin
        slot_cnt  <= '0;
        col_idx   <= col_idx + 2'd1;
        shift_col <= {shift_col[2:0], shift_col[3]};
        snapshot[{col_idx, 2'b00} +: 4] <= row_s2;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  keypad_decode u_decode (
    .snapshot (snapshot),
    .result   (res)
  );

  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             held_d, fire;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    held_d  = key_held;
    fire    = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    if (scan_done) begin
      case (state_q)
        IDLE: if (res.single) begin
          state_d = CONFIRM;
          cand_d  = res.code;
          cnt_d   = CNT_W'(1);
        end
        CONFIRM: if (res.single && res.code == cand_q) begin
          if (cnt_inc == CNT_DONE) begin
            fire    = 1'b1;
            held_d  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        HELD: if (res.none) begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(1);
        end
        RELEASE: if (res.none) begin
          if (cnt_inc == CNT_DONE) begin
            held_d  = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = HELD;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      key_value <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_valid <= fire;
      key_held  <= held_d;
      if (fire) key_value <= cand_q;
    end
  end

endmodule
